// File: rtl/cal_pkg.sv
// rtl/cal_pkg.sv - shared types, month constants and leap-year helpers for the BCD calendar
package cal_pkg;

    typedef logic [3:0] bcd_t;

    // Month numbers as BCD pairs {tens, ones}
    localparam logic [7:0] MON_JAN = 8'h01;
    localparam logic [7:0] MON_FEB = 8'h02;
    localparam logic [7:0] MON_MAR = 8'h03;
    localparam logic [7:0] MON_APR = 8'h04;
    localparam logic [7:0] MON_MAY = 8'h05;
    localparam logic [7:0] MON_JUN = 8'h06;
    localparam logic [7:0] MON_JUL = 8'h07;
    localparam logic [7:0] MON_AUG = 8'h08;
    localparam logic [7:0] MON_SEP = 8'h09;
    localparam logic [7:0] MON_OCT = 8'h10;
    localparam logic [7:0] MON_NOV = 8'h11;
    localparam logic [7:0] MON_DEC = 8'h12;

    // Last-day values as BCD pairs
    localparam logic [7:0] DAYS_30  = 8'h30;
    localparam logic [7:0] DAYS_31  = 8'h31;
    localparam logic [7:0] FEB_LEAP = 8'h29;
    localparam logic [7:0] FEB_NORM = 8'h28;

    // Reset date 2000-01-01, a leap year and a Saturday
    localparam bcd_t       RST_YM = 4'd2;
    localparam bcd_t       RST_YH = 4'd0;
    localparam bcd_t       RST_YT = 4'd0;
    localparam bcd_t       RST_YO = 4'd0;
    localparam bcd_t       RST_MT = 4'd0;
    localparam bcd_t       RST_MO = 4'd1;
    localparam bcd_t       RST_DT = 4'd0;
    localparam bcd_t       RST_DO = 4'd1;
    localparam logic       RST_LY = 1'b1;
    localparam logic [2:0] RST_WD = 3'd6;

    function automatic logic isBcd(input bcd_t digit);
        isBcd = (digit <= 4'd9);
    endfunction

    // 10 is 2 mod 4, so an odd tens digit shifts the ones residue by 2.
    function automatic logic pairDiv4(input bcd_t tens, input bcd_t ones);
        if (tens[0])
            pairDiv4 = (ones == 4'd2) || (ones == 4'd6);
        else
            pairDiv4 = (ones == 4'd0) || (ones == 4'd4) || (ones == 4'd8);
    endfunction

    // Century years (xx00) fall back to the upper pair, which gives the 400 rule.
    function automatic logic isLeapYear(input bcd_t ym, input bcd_t yh,
                                        input bcd_t yt, input bcd_t yo);
        if ((yt == 4'd0) && (yo == 4'd0))
            isLeapYear = pairDiv4(ym, yh);
        else
            isLeapYear = pairDiv4(yt, yo);
    endfunction

endpackage

// File: rtl/month_last_day.sv
// rtl/month_last_day.sv - combinational last-day-of-month lookup in BCD
//
// Ports:
//   MT, MO  : BCD month digits
//   leap    : year of interest is a leap year
//   lastDay : last valid day as a BCD pair {tens, ones}; 00 for an invalid month
module month_last_day
    import cal_pkg::*;
(
    input  logic [3:0] MT,
    input  logic [3:0] MO,
    input  logic       leap,
    output logic [7:0] lastDay
);

    always_comb begin
        case ({MT, MO})
            MON_JAN, MON_MAR, MON_MAY, MON_JUL,
            MON_AUG, MON_OCT, MON_DEC:           lastDay = DAYS_31;
            MON_APR, MON_JUN, MON_SEP, MON_NOV:  lastDay = DAYS_30;
            MON_FEB:                             lastDay = leap ? FEB_LEAP : FEB_NORM;
            // Zero makes any day compare as out of range in the load check
            default:                             lastDay = 8'h00;
        endcase
    end

endmodule

// File: rtl/bcd_calendar_counter.sv
// rtl/bcd_calendar_counter.sv - BCD Gregorian calendar with day tick and validated load
//
// Optional feature macro: CAL_WEEKDAY_EN (adds ld_wd input and WD weekday output)
//
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   tick                    : advance one day
//   load                    : load request (wins over tick)
//   ld_ym..ld_do            : BCD date to load
//   ld_wd / WD              : weekday load / output, 0 = Sunday (CAL_WEEKDAY_EN only)
//   YM, YH, YT, YO          : year digits
//   MT, MO, DT, DO          : month and day digits
//   LY                      : current year is leap
//   year_wrap               : pulse on 9999 -> 0000
//   ld_err                  : pulse on rejected load
module bcd_calendar_counter
    import cal_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] ld_ym,
    input  logic [3:0] ld_yh,
    input  logic [3:0] ld_yt,
    input  logic [3:0] ld_yo,
    input  logic [3:0] ld_mt,
    input  logic [3:0] ld_mo,
    input  logic [3:0] ld_dt,
    input  logic [3:0] ld_do,
`ifdef CAL_WEEKDAY_EN
    input  logic [2:0] ld_wd,
    output logic [2:0] WD,
`endif
    output logic [3:0] YM,
    output logic [3:0] YH,
    output logic [3:0] YT,
    output logic [3:0] YO,
    output logic [3:0] MT,
    output logic [3:0] MO,
    output logic [3:0] DT,
    output logic [3:0] DO,
    output logic       LY,
    output logic       year_wrap,
    output logic       ld_err
);

    bcd_t       nYm, nYh, nYt, nYo, nMt, nMo, nDt, nDo;
    logic       nLy, nWrap, nErr;
    logic [7:0] curLast;
    logic [7:0] ldLast;
    logic       ldLeap;
    logic       ldDigitsOk, ldMonthOk, ldDayOk, ldOk;
`ifdef CAL_WEEKDAY_EN
    logic [2:0] nWd;
`endif

    // Running date: LY is registered with the year, so it is valid for the current month
    month_last_day uCurLast (
        .MT      (MT),
        .MO      (MO),
        .leap    (LY),
        .lastDay (curLast)
    );

    // Load path: month length uses the leap status of the year being loaded
    assign ldLeap = isLeapYear(ld_ym, ld_yh, ld_yt, ld_yo);

    month_last_day uLdLast (
        .MT      (ld_mt),
        .MO      (ld_mo),
        .leap    (ldLeap),
        .lastDay (ldLast)
    );

    always_comb begin
        ldDigitsOk = isBcd(ld_ym) && isBcd(ld_yh) && isBcd(ld_yt) && isBcd(ld_yo) &&
                     isBcd(ld_mt) && isBcd(ld_mo) && isBcd(ld_dt) && isBcd(ld_do);
`ifdef CAL_WEEKDAY_EN
        ldDigitsOk = ldDigitsOk && (ld_wd <= 3'd6);
`endif
        // BCD pairs order like binary once every nibble is known to be 0-9
        ldMonthOk = ({ld_mt, ld_mo} != 8'h00) && ({ld_mt, ld_mo} <= MON_DEC);
        ldDayOk   = ({ld_dt, ld_do} != 8'h00) && ({ld_dt, ld_do} <= ldLast);
        ldOk      = ldDigitsOk && ldMonthOk && ldDayOk;
    end

    always_comb begin
        nYm   = YM;
        nYh   = YH;
        nYt   = YT;
        nYo   = YO;
        nMt   = MT;
        nMo   = MO;
        nDt   = DT;
        nDo   = DO;
        nWrap = 1'b0;
        nErr  = 1'b0;
`ifdef CAL_WEEKDAY_EN
        nWd   = WD;
`endif

        if (load) begin
            if (ldOk) begin
                nYm = ld_ym;
                nYh = ld_yh;
                nYt = ld_yt;
                nYo = ld_yo;
                nMt = ld_mt;
                nMo = ld_mo;
                nDt = ld_dt;
                nDo = ld_do;
`ifdef CAL_WEEKDAY_EN
                nWd = ld_wd;
`endif
            end else begin
                nErr = 1'b1;
            end
        end else if (tick) begin
`ifdef CAL_WEEKDAY_EN
            nWd = (WD == 3'd6) ? 3'd0 : WD + 3'd1;
`endif
            if ({DT, DO} != curLast) begin
                if (DO == 4'd9) begin
                    nDo = 4'd0;
                    nDt = DT + 4'd1;
                end else begin
                    nDo = DO + 4'd1;
                end
            end else begin
                nDt = 4'd0;
                nDo = 4'd1;
                if ({MT, MO} != MON_DEC) begin
                    if (MO == 4'd9) begin
                        nMt = 4'd1;
                        nMo = 4'd0;
                    end else begin
                        nMo = MO + 4'd1;
                    end
                end else begin
                    nMt = 4'd0;
                    nMo = 4'd1;
                    // Four-digit BCD ripple increment of the year
                    if (YO != 4'd9) begin
                        nYo = YO + 4'd1;
                    end else begin
                        nYo = 4'd0;
                        if (YT != 4'd9) begin
                            nYt = YT + 4'd1;
                        end else begin
                            nYt = 4'd0;
                            if (YH != 4'd9) begin
                                nYh = YH + 4'd1;
                            end else begin
                                nYh = 4'd0;
                                if (YM != 4'd9) begin
                                    nYm = YM + 4'd1;
                                end else begin
                                    nYm   = 4'd0;
                                    nWrap = 1'b1;
                                end
                            end
                        end
                    end
                end
            end
        end

        nLy = isLeapYear(nYm, nYh, nYt, nYo);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            YM        <= RST_YM;
            YH        <= RST_YH;
            YT        <= RST_YT;
            YO        <= RST_YO;
            MT        <= RST_MT;
            MO        <= RST_MO;
            DT        <= RST_DT;
            DO        <= RST_DO;
            LY        <= RST_LY;
            year_wrap <= 1'b0;
            ld_err    <= 1'b0;
`ifdef CAL_WEEKDAY_EN
            WD        <= RST_WD;
`endif
        end else begin
            YM        <= nYm;
            YH        <= nYh;
            YT        <= nYt;
            YO        <= nYo;
            MT        <= nMt;
            MO        <= nMo;
            DT        <= nDt;
            DO        <= nDo;
            LY        <= nLy;
            year_wrap <= nWrap;
            ld_err    <= nErr;
`ifdef CAL_WEEKDAY_EN
            WD        <= nWd;
`endif
        end
    end

endmodule
